snn_cfg_loader: RTL and testbench
=================================

# snn_cfg_loader

Parametrised configuration front end for the delayed-spike two-layer SNN. It replaces wide, pin-level weight/delay/parameter buses with a narrow valid/ready word stream into a shadow register bank. Each complete load commits atomically to the active register bank that drives the network. It also unpacks each layer's 4-bit-style delay fields into separate delay-value and delay-enable vectors, and gates the network enable until a valid configuration exists.

## Interface
- M1, 24, layer-1 inputs
- N1, 8, layer-1 neurons
- N2, 2, layer-2 neurons
- WBITS, 2, bits per synaptic weight
- DBITS, 3, delay-value bits; each packed delay field is DBITS+1 bits (value LSBs, enable MSB)
- PBITS, 2, width of threshold/decay/refractory_period
- BUS_W, 8, config word width
- Derived: CFG_BITS = (N1*M1+N2*N1)*(WBITS+DBITS+1) + 3*PBITS; CFG_WORDS = ceil(CFG_BITS/BUS_W)

- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cfg_start  in  1  begin (or restart) a load
- cfg_valid  in  1  cfg_data valid
- cfg_data  in  BUS_W  config word
- cfg_ready  out  1  loader accepts a word
- enable  in  1  network enable request
- net_enable  out  1  enable & cfg_loaded
- weights1  out  N1*M1*WBITS  active layer-1 weights
- weights2  out  N2*N1*WBITS  active layer-2 weights
- delay_values1 / delays1  out  N1*M1*DBITS / N1*M1  active layer-1 delays / enables
- delay_values2 / delays2  out  N2*N1*DBITS / N2*N1  active layer-2 delays / enables
- threshold, decay, refractory_period  out  PBITS each  active neuron parameters
- cfg_loaded  out  1  active bank holds a committed config
- commit_done  out  1  one-cycle pulse after commit
- load_abort  out  1  one-cycle pulse when an in-progress load is restarted
- busy  out  1  state != IDLE

## Operation
- Stream bit order (LSB first, word 0 = bits BUS_W-1:0):
  - weights layer 1
  - weights layer 2
  - delay fields layer 1
  - delay fields layer 2
  - threshold
  - decay
  - refractory_period
- Padding bits of the last word are ignored.
- Delay field i occupies bits [i*(DBITS+1) +: DBITS+1]. delay_values[i*DBITS +: DBITS] = field[DBITS-1:0]; delays[i] = field[DBITS].
- FSM: IDLE, LOAD, COMMIT.
  - IDLE: cfg_ready=0. cfg_start -> LOAD, word counter cleared to 0.
  - LOAD: cfg_ready=1.
    - Each accepted word (cfg_valid & cfg_ready) is written into shadow word [counter]; counter increments.
    - Acceptance of word CFG_WORDS-1 -> COMMIT.
    - cfg_start in LOAD: counter cleared to 0, load_abort pulses, stay in LOAD. A word presented in that same cycle is discarded.
  - COMMIT: cfg_ready=0; shadow bank copied to active bank; cfg_loaded set to 1; commit_done pulses; -> IDLE. cfg_start is ignored in COMMIT.
- The active bank changes only at commit. An aborted or partial load never alters the active outputs.
- Shadow words not rewritten by a load hold their previous values. A complete load always rewrites all of them.

## Timing
- Reset (reset=0 at an edge):
  - State IDLE, counter 0.
  - Shadow and active banks all 0.
  - cfg_loaded=0, commit_done=0, load_abort=0, busy=0, cfg_ready=0, net_enable=0.
- cfg_ready and busy are registered from state. The first word is accepted one cycle after cfg_start is sampled.
- Throughput is one word per cycle with no bubbles; cfg_valid may drop at any time without losing position.
- Commit timing, with the last word accepted at edge k:
  - COMMIT occupies cycle k→k+1.
  - Active outputs, cfg_loaded and commit_done update at edge k+1.
  - commit_done is high for exactly one cycle.
- net_enable is combinational: enable & cfg_loaded.
- Reset mid-load discards the partial load and also clears the active bank.

## Configuration
- SNN_CFG_READBACK_EN defined:
  - Adds input rb_addr, width clog2(CFG_WORDS).
  - Adds output rb_data, width BUS_W: active-bank word [rb_addr], registered, 1-cycle latency.
  - rb_data resets to 0; padding bits read 0; an out-of-range rb_addr returns 0.
- SNN_CFG_READBACK_EN undefined: neither port exists and no readback logic is built.

## Test plan
Default parameters give CFG_BITS=1254 and CFG_WORDS=157.
- Full load, word n = n[7:0]:
  - weights1[7:0]=8'h00, weights1[15:8]=8'h01.
  - commit_done pulses once, exactly 1 cycle after the word-156 handshake.
  - cfg_loaded=1; net_enable follows enable.
- Delay unpack: word 52 = 8'hAB -> delay_values1[2:0]=3'b011, delays1[0]=1, delay_values1[5:3]=3'b010, delays1[1]=1.
- Parameters: word 156 = 8'hE4 -> threshold=2'b00, decay=2'b01, refractory_period=2'b10; bits 7:6 ignored.
- Backpressure: cfg_valid toggling 1/0 every cycle during a full load -> identical active bank to the gap-free load, with the commit 156 cycles later.
- Abort: after a committed config A, start load B and send 10 words, then assert cfg_start:
  - load_abort pulses; counter returns to 0.
  - Outputs remain A and cfg_loaded stays 1 until B completes.
- Reset low mid-load (word 80) -> all outputs 0, cfg_loaded=0, state IDLE; a subsequent full load commits normally.

Source files
------------

// File: rtl/snn_cfg_loader.sv
// snn_cfg_loader
//   Configuration front end for the delayed-spike two-layer SNN. A narrow
//   valid/ready word stream fills a shadow bank. A complete load is copied
//   atomically into the active bank that drives the network. Packed delay
//   fields are split into delay-value and delay-enable vectors, and the
//   network enable is gated until a configuration has been committed.
//
//   Stream layout, LSB first (word 0 = bits BUS_W-1:0):
//     weights1 | weights2 | delay fields L1 | delay fields L2 |
//     threshold | decay | refractory_period. Padding bits of the last word
//     are dropped.
//
// Ports
//   clk, reset          clock, synchronous active-low reset
//   cfg_start           begin / restart a load
//   cfg_valid/cfg_data  config word stream; cfg_ready = loader accepts
//   enable/net_enable   network enable request / gated enable
//   weights*, delay_values*, delays*, threshold, decay, refractory_period
//                       active-bank outputs
//   cfg_loaded          active bank holds a committed configuration
//   commit_done         one-cycle pulse after commit
//   load_abort          one-cycle pulse when a running load is restarted
//   busy                loader not idle
//   rb_addr/rb_data     active-bank word readback (SNN_CFG_READBACK_EN only)
//
// Optional feature macro: SNN_CFG_READBACK_EN
module snn_cfg_loader #(
  parameter  int unsigned M1        = 24,
  parameter  int unsigned N1        = 8,
  parameter  int unsigned N2        = 2,
  parameter  int unsigned WBITS     = 2,
  parameter  int unsigned DBITS     = 3,
  parameter  int unsigned PBITS     = 2,
  parameter  int unsigned BUS_W     = 8,
  localparam int unsigned CFG_BITS  = (N1*M1 + N2*N1)*(WBITS + DBITS + 1) + 3*PBITS,
  localparam int unsigned CFG_WORDS = (CFG_BITS + BUS_W - 1) / BUS_W,
  localparam int unsigned CNT_W     = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic                      cfg_valid,
  input  logic [BUS_W-1:0]          cfg_data,
  output logic                      cfg_ready,
  input  logic                      enable,
  output logic                      net_enable,
  output logic [N1*M1*WBITS-1:0]    weights1,
  output logic [N2*N1*WBITS-1:0]    weights2,
  output logic [N1*M1*DBITS-1:0]    delay_values1,
  output logic [N1*M1-1:0]          delays1,
  output logic [N2*N1*DBITS-1:0]    delay_values2,
  output logic [N2*N1-1:0]          delays2,
  output logic [PBITS-1:0]          threshold,
  output logic [PBITS-1:0]          decay,
  output logic [PBITS-1:0]          refractory_period,
  output logic                      cfg_loaded,
  output logic                      commit_done,
  output logic                      load_abort,
  output logic                      busy
`ifdef SNN_CFG_READBACK_EN
  ,
  input  logic [CNT_W-1:0]          rb_addr,
  output logic [BUS_W-1:0]          rb_data
`endif
);

  localparam int unsigned DF     = DBITS + 1;
  localparam int unsigned OFF_W2 = N1*M1*WBITS;
  localparam int unsigned OFF_D1 = OFF_W2 + N2*N1*WBITS;
  localparam int unsigned OFF_D2 = OFF_D1 + N1*M1*DF;
  localparam int unsigned OFF_P  = OFF_D2 + N2*N1*DF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ready;
  logic                r_busy;
  logic                r_loaded;
  logic                r_commit;
  logic                r_abort;
  logic [CFG_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0] r_active;

  logic                w_accept;
  logic                w_last;

  // A word presented together with cfg_start is discarded.
  assign w_accept = (r_state == S_LOAD) && cfg_valid && !cfg_start;
  assign w_last   = (r_cnt == CNT_W'(CFG_WORDS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_loaded <= 1'b0;
      r_commit <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      r_abort  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cfg_start) begin
            r_cnt   <= '0;
            r_abort <= 1'b1;
          end else if (cfg_valid) begin
            if (w_last) begin
              r_state <= S_COMMIT;
              r_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_busy   <= 1'b0;
          r_loaded <= 1'b1;
          r_commit <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Shadow bank is stored bit-exact (no padding); each bit belongs to word
  // b/BUS_W and is written only when that word is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shadow <= '0;
    end else if (w_accept) begin
      for (int unsigned b = 0; b < CFG_BITS; b++) begin
        if (b / BUS_W == 32'(r_cnt)) begin
          r_shadow[b] <= cfg_data[b % BUS_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_active <= '0;
    end else if (r_state == S_COMMIT) begin
      r_active <= r_shadow;
    end
  end

  assign cfg_ready   = r_ready;
  assign busy        = r_busy;
  assign cfg_loaded  = r_loaded;
  assign commit_done = r_commit;
  assign load_abort  = r_abort;
  assign net_enable  = enable & r_loaded;

  assign weights1          = r_active[0      +: N1*M1*WBITS];
  assign weights2          = r_active[OFF_W2 +: N2*N1*WBITS];
  assign threshold         = r_active[OFF_P             +: PBITS];
  assign decay             = r_active[OFF_P + PBITS     +: PBITS];
  assign refractory_period = r_active[OFF_P + 2*PBITS   +: PBITS];

  // Each packed delay field: value in the low DBITS, enable in the MSB.
  for (genvar i = 0; i < N1*M1; i++) begin : g_delay1
    assign delay_values1[i*DBITS +: DBITS] = r_active[OFF_D1 + i*DF +: DBITS];
    assign delays1[i]                      = r_active[OFF_D1 + i*DF + DBITS];
  end

  for (genvar i = 0; i < N2*N1; i++) begin : g_delay2
    assign delay_values2[i*DBITS +: DBITS] = r_active[OFF_D2 + i*DF +: DBITS];
    assign delays2[i]                      = r_active[OFF_D2 + i*DF + DBITS];
  end

`ifdef SNN_CFG_READBACK_EN
  logic [BUS_W-1:0] w_rb_word;

  // Bits past CFG_BITS (padding or out-of-range address) read as 0.
  always_comb begin
    w_rb_word = '0;
    if (32'(rb_addr) < CFG_WORDS) begin
      for (int unsigned j = 0; j < BUS_W; j++) begin
        if (32'(rb_addr) * BUS_W + j < CFG_BITS) begin
          w_rb_word[j] = r_active[32'(rb_addr) * BUS_W + j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rb_data <= '0;
    end else begin
      rb_data <= w_rb_word;
    end
  end
`endif

endmodule

// File: tb/tb_snn_cfg_loader.sv
// Self-checking bench for snn_cfg_loader at default parameters.
// Loads push their expected image into a scoreboard queue; the image is
// popped and compared against the active outputs when commit_done appears.
module tb_snn_cfg_loader;

  localparam int M1 = 24, N1 = 8, N2 = 2, WBITS = 2, DBITS = 3, PBITS = 2, BUS_W = 8;
  localparam int CFG_BITS  = 1254;
  localparam int CFG_WORDS = 157;
  localparam int OFF_W2 = 384, OFF_D1 = 416, OFF_D2 = 1184, OFF_P = 1248;

  typedef logic [CFG_BITS-1:0] img_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_start;
  logic         cfg_valid;
  logic [7:0]   cfg_data;
  logic         cfg_ready;
  logic         enable;
  logic         net_enable;
  logic [383:0] weights1;
  logic [31:0]  weights2;
  logic [575:0] delay_values1;
  logic [191:0] delays1;
  logic [47:0]  delay_values2;
  logic [15:0]  delays2;
  logic [1:0]   threshold, decay, refractory_period;
  logic         cfg_loaded, commit_done, load_abort, busy;
`ifdef SNN_CFG_READBACK_EN
  logic [7:0]   rb_addr;
  logic [7:0]   rb_data;
`endif

  snn_cfg_loader #(
    .M1(M1), .N1(N1), .N2(N2), .WBITS(WBITS), .DBITS(DBITS), .PBITS(PBITS), .BUS_W(BUS_W)
  ) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .enable(enable), .net_enable(net_enable),
    .weights1(weights1), .weights2(weights2),
    .delay_values1(delay_values1), .delays1(delays1),
    .delay_values2(delay_values2), .delays2(delays2),
    .threshold(threshold), .decay(decay), .refractory_period(refractory_period),
    .cfg_loaded(cfg_loaded), .commit_done(commit_done), .load_abort(load_abort), .busy(busy)
`ifdef SNN_CFG_READBACK_EN
    , .rb_addr(rb_addr), .rb_data(rb_data)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  logic [7:0] words [CFG_WORDS];
  logic [7:0] saved [CFG_WORDS];
  img_t sb_q [$];
  img_t cur_img;
  logic loaded_exp;

  function automatic img_t pack_words();
    img_t r;
    r = '0;
    for (int n = 0; n < CFG_WORDS; n++)
      for (int j = 0; j < 8; j++)
        if (n*8 + j < CFG_BITS) r[n*8 + j] = words[n][j];
    return r;
  endfunction

  // Drives one full load starting with a cfg_start cycle. abort_mode drives a
  // garbage word alongside cfg_start (DUT already in LOAD) that must be dropped.
  task automatic do_load(input bit gap, input bit abort_mode, output int lat);
    int n, cyc, since_last;
    bit ready_bad, mid_done;
    img_t e;
    logic [575:0] e_dv1;
    logic [191:0] e_d1;
    logic [47:0]  e_dv2;
    logic [15:0]  e_d2;
    ready_bad = 0;
    mid_done  = 0;
    sb_q.push_back(pack_words());
    cfg_start = 1'b1;
    cfg_valid = abort_mode;
    cfg_data  = 8'hFF;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    lat = 0;
    if (abort_mode) begin
      total++;
      if (load_abort !== 1'b1) begin bad++; $display("FAIL abort_pulse: got %b want 1", load_abort); end
      total++;
      if (cfg_loaded !== 1'b1 || weights1 !== cur_img[383:0]) begin
        bad++; $display("FAIL abort_hold: loaded=%b w1=%h want loaded=1 w1=%h", cfg_loaded, weights1, cur_img[383:0]);
      end
    end
    n = 0; cyc = 0;
    while (n < CFG_WORDS) begin
      cfg_valid = gap ? (cyc % 2 == 0) : 1'b1;
      cfg_data  = words[n];
      if (cfg_valid && !cfg_ready) ready_bad = 1;
      if (n == 100 && !mid_done) begin
        mid_done = 1;
        total++;
        if (busy !== 1'b1 || cfg_loaded !== loaded_exp || weights1 !== cur_img[383:0] ||
            threshold !== cur_img[OFF_P +: 2] || delays1 === 'x) begin
          bad++;
          $display("FAIL partial_hold: busy=%b loaded=%b w1=%h want busy=1 loaded=%b w1=%h",
                   busy, cfg_loaded, weights1, loaded_exp, cur_img[383:0]);
        end
      end
      @(posedge clk); #1;
      lat++;
      if (abort_mode && lat == 1) begin
        total++;
        if (load_abort !== 1'b0) begin bad++; $display("FAIL abort_one_cycle: got %b want 0", load_abort); end
      end
      if (cfg_valid) n++;
      cyc++;
    end
    cfg_valid = 1'b0;
    total++;
    if (ready_bad) begin bad++; $display("FAIL ready_in_load: got 0 want 1"); end
    since_last = 0;
    while (commit_done !== 1'b1 && since_last < 4) begin
      @(posedge clk); #1;
      lat++;
      since_last++;
    end
    total++;
    if (since_last != 1) begin bad++; $display("FAIL commit_latency: got %0d want 1", since_last); end
    e = sb_q.pop_front();
    for (int i = 0; i < 192; i++) begin
      e_dv1[i*3 +: 3] = e[OFF_D1 + i*4 +: 3];
      e_d1[i]         = e[OFF_D1 + i*4 + 3];
    end
    for (int i = 0; i < 16; i++) begin
      e_dv2[i*3 +: 3] = e[OFF_D2 + i*4 +: 3];
      e_d2[i]         = e[OFF_D2 + i*4 + 3];
    end
    total++;
    if (weights1 !== e[0 +: 384]) begin bad++; $display("FAIL weights1: got %h want %h", weights1, e[0 +: 384]); end
    total++;
    if (weights2 !== e[OFF_W2 +: 32]) begin bad++; $display("FAIL weights2: got %h want %h", weights2, e[OFF_W2 +: 32]); end
    total++;
    if (delay_values1 !== e_dv1) begin bad++; $display("FAIL delay_values1: got %h want %h", delay_values1, e_dv1); end
    total++;
    if (delays1 !== e_d1) begin bad++; $display("FAIL delays1: got %h want %h", delays1, e_d1); end
    total++;
    if (delay_values2 !== e_dv2 || delays2 !== e_d2) begin
      bad++; $display("FAIL delays2: got %h/%h want %h/%h", delay_values2, delays2, e_dv2, e_d2);
    end
    total++;
    if ({threshold, decay, refractory_period} !== {e[OFF_P +: 2], e[OFF_P+2 +: 2], e[OFF_P+4 +: 2]}) begin
      bad++; $display("FAIL params: got %b %b %b want %b %b %b", threshold, decay, refractory_period,
                      e[OFF_P +: 2], e[OFF_P+2 +: 2], e[OFF_P+4 +: 2]);
    end
    total++;
    if (cfg_loaded !== 1'b1) begin bad++; $display("FAIL loaded_after_commit: got %b want 1", cfg_loaded); end
    cur_img    = e;
    loaded_exp = 1'b1;
    @(posedge clk); #1;
    total++;
    if (commit_done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL commit_pulse_end: commit_done=%b busy=%b want 0 0", commit_done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({cfg_ready, busy, cfg_loaded, commit_done, load_abort, net_enable} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000",
                      {cfg_ready, busy, cfg_loaded, commit_done, load_abort, net_enable});
    end
    total++;
    if ({weights1, weights2, delay_values1, delays1, delay_values2, delays2,
         threshold, decay, refractory_period} !== '0) begin
      bad++; $display("FAIL reset_bank: w1=%h thr=%b want 0", weights1, threshold);
    end
    reset = 1'b1;
    cur_img = '0;
    loaded_exp = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_load();
    int lat;
    for (int n = 0; n < CFG_WORDS; n++) words[n] = 8'(n);
    enable = 1'b0;
    do_load(0, 0, lat);
    total++;
    if (weights1[15:0] !== 16'h0100) begin bad++; $display("FAIL full_w1_low: got %h want 0100", weights1[15:0]); end
    total++;
    if (lat != 158) begin bad++; $display("FAIL full_latency: got %0d want 158", lat); end
    total++;
    if (net_enable !== 1'b0) begin bad++; $display("FAIL net_enable_off: got %b want 0", net_enable); end
    enable = 1'b1; #1;
    total++;
    if (net_enable !== 1'b1) begin bad++; $display("FAIL net_enable_on: got %b want 1", net_enable); end
  endtask

  task automatic test_delay_params();
    int lat;
    for (int n = 0; n < CFG_WORDS; n++) words[n] = 8'($urandom);
    words[52]  = 8'hAB;
    words[156] = 8'hE4;
    saved = words;
    do_load(0, 0, lat);
    total++;
    if ({delays1[1], delay_values1[5:3], delays1[0], delay_values1[2:0]} !== 8'b1_010_1_011) begin
      bad++; $display("FAIL delay_unpack: got %b want 10101011",
                      {delays1[1], delay_values1[5:3], delays1[0], delay_values1[2:0]});
    end
    total++;
    if ({threshold, decay, refractory_period} !== 6'b00_01_10) begin
      bad++; $display("FAIL param_unpack: got %b want 000110", {threshold, decay, refractory_period});
    end
  endtask

  task automatic test_backpressure();
    int lat;
    for (int n = 0; n < CFG_WORDS; n++) words[n] = ~saved[n];
    do_load(0, 0, lat);
    words = saved;
    do_load(1, 0, lat);
    total++;
    if (lat != 158 + 156) begin bad++; $display("FAIL gap_latency: got %0d want 314", lat); end
  endtask

  task automatic test_abort();
    int lat;
    for (int n = 0; n < CFG_WORDS; n++) words[n] = 8'($urandom);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      cfg_valid = 1'b1;
      cfg_data  = 8'(n * 37 + 5);
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    total++;
    if (load_abort !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL pre_abort: abort=%b busy=%b want 0 1", load_abort, busy);
    end
    do_load(0, 1, lat);
    total++;
    if (lat != 158) begin bad++; $display("FAIL abort_latency: got %0d want 158", lat); end
  endtask

  task automatic test_reset_midload();
    int lat;
    for (int n = 0; n < CFG_WORDS; n++) words[n] = 8'($urandom);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int n = 0; n < 80; n++) begin
      cfg_valid = 1'b1;
      cfg_data  = words[n];
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({cfg_ready, busy, cfg_loaded, commit_done, load_abort, net_enable} !== 6'b0) begin
      bad++; $display("FAIL midreset_ctrl: got %b want 000000",
                      {cfg_ready, busy, cfg_loaded, commit_done, load_abort, net_enable});
    end
    total++;
    if ({weights1, weights2, delay_values1, delays1, delay_values2, delays2,
         threshold, decay, refractory_period} !== '0) begin
      bad++; $display("FAIL midreset_bank: w1=%h want 0", weights1);
    end
    reset = 1'b1;
    cur_img = '0;
    loaded_exp = 1'b0;
    @(posedge clk); #1;
    do_load(0, 0, lat);
  endtask

`ifdef SNN_CFG_READBACK_EN
  task automatic test_readback();
    int addrs [4];
    logic [7:0] exp;
    addrs = '{0, 52, 156, 200};
    for (int k = 0; k < 4; k++) begin
      rb_addr = 8'(addrs[k]);
      @(posedge clk); #1;
      if (addrs[k] >= CFG_WORDS) exp = 8'h00;
      else if (addrs[k] == CFG_WORDS - 1) exp = words[addrs[k]] & 8'h3F;
      else exp = words[addrs[k]];
      total++;
      if (rb_data !== exp) begin bad++; $display("FAIL readback[%0d]: got %h want %h", addrs[k], rb_data, exp); end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; enable = 1'b0;
`ifdef SNN_CFG_READBACK_EN
    rb_addr = '0;
`endif
    test_reset();
    test_full_load();
    test_delay_params();
    test_backpressure();
    test_abort();
    test_reset_midload();
`ifdef SNN_CFG_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
